// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HANDLING,
        RET
    } irq_state_e;

    localparam int          NUM_IRQ           = 16;
    localparam int          IRQ_CAUSE_BASE    = 16;
    localparam logic [31:0] EXC_ILLEGAL_CAUSE = 32'h0000_0002;
    localparam logic [31:0] INT_CAUSE_FLAG    = 32'h8000_0000;

endpackage

// File: rtl/irq_priority_encoder.sv
// Lowest-index-first selection over the eligible request lines.
module irq_priority_encoder
    import irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    output logic [3:0]         idx,
    output logic               valid
);

    always_comb begin
        idx   = '0;
        valid = |req;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Single-level interrupt controller: exception/interrupt trap request,
// mcause generation and one-shot acknowledge after mret.
module irq_controller
    import irq_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               exception_i,
    input  logic [NUM_IRQ-1:0] irq_req_i,
    input  logic [31:0]        mie_i,
    input  logic               mret_i,
    input  logic               stall_i,
    output logic               trap_o,
    output logic [31:0]        mcause_o,
    output logic [NUM_IRQ-1:0] irq_ret_o,
    output logic               busy_o
);

    irq_state_e         state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [NUM_IRQ-1:0] eligible;
    logic [3:0]         sel_idx;
    logic               sel_valid;
    logic               take;
    logic               unused_mie;

    assign eligible   = irq_req_i & mie_i[31:16];
    assign unused_mie = ^mie_i[15:0];

    irq_priority_encoder u_prio (
        .req   (eligible),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    // Exceptions always win; an interrupt is only taken from a quiet IDLE.
    assign take = (state_q == IDLE) && sel_valid && !exception_i && !stall_i;

    always_comb begin
        trap_o   = 1'b0;
        mcause_o = '0;
        if (rst_i) begin
            if (exception_i) begin
                trap_o   = 1'b1;
                mcause_o = EXC_ILLEGAL_CAUSE;
            end else if (take) begin
                trap_o   = 1'b1;
                mcause_o = INT_CAUSE_FLAG
                         | (32'(IRQ_CAUSE_BASE) + 32'(sel_idx));
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = HANDLING;
                    idx_d   = sel_idx;
                end
            end
            HANDLING: begin
                if (mret_i && !exception_i) begin
                    state_d = RET;
                end
            end
            RET: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign irq_ret_o = (state_q == RET) ? (NUM_IRQ'(1) << idx_q) : '0;
    assign busy_o    = (state_q != IDLE);

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have clk_i, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have rst_i, input, 1: asynchronous reset, active-low; asserts immediately, releases synchronously to clk_i.
REQ-003 SHALL have exception_i, input, 1: illegal-instruction indication from decoder, valid for the current cycle.
REQ-004 SHALL have irq_req_i, input, 16: level interrupt requests from peripherals; line n maps to cause 16+n.
REQ-005 SHALL have mie_i, input, 32: mie CSR value; bit 16+n enables line n; bits 15:0 ignored.
REQ-006 SHALL have mret_i, input, 1: core is executing mret this cycle.
REQ-007 SHALL have stall_i, input, 1: core stalled; no interrupt is taken while high.
REQ-008 SHALL have trap_o, output, 1: trap request to core and CSR controller (drives its trap input).
REQ-009 SHALL have mcause_o, output, 32: cause value written to mcause when trap_o is high.
REQ-010 SHALL have irq_ret_o, output, 16: one-hot, one-cycle acknowledge to the serviced peripheral.
REQ-011 SHALL have busy_o, output, 1: high while an interrupt is in service (state HANDLING or RET).

Function
REQ-012 SHALL implement FSM states IDLE, HANDLING, RET.
REQ-013 SHALL compute eligible = irq_req_i & mie_i[31:16]; selected line = lowest set index of eligible.
REQ-014 SHALL assert trap_o combinationally when exception_i=1, in any state.
REQ-015 SHALL assert trap_o combinationally when state=IDLE, eligible!=0, exception_i=0, stall_i=0 (interrupt take).
REQ-016 SHALL drive mcause_o = 32'h0000_0002 when exception_i=1; else {1'b1, 26'b0, 5'(16+selected)}; else 0.
REQ-017 SHALL, on an interrupt take, register the selected index and move IDLE->HANDLING at the next edge.
REQ-018 SHALL, when exception_i and an eligible interrupt coincide in IDLE, report only the exception; state stays IDLE and the interrupt may be taken on a later cycle.
REQ-019 SHALL ignore irq_req_i in HANDLING and RET (no nesting); exception_i is still reported with state unchanged.
REQ-020 SHALL, on mret_i=1 with exception_i=0 in HANDLING, move to RET at the next edge.
REQ-021 SHALL assert irq_ret_o = 1<<captured index for exactly the one RET cycle, then return to IDLE.
REQ-022 SHALL ignore mret_i in IDLE and RET, and also in HANDLING when exception_i=1 in the same cycle.
REQ-023 SHALL keep the captured index through HANDLING, and pulse the same line in RET even if that request dropped meanwhile.
REQ-024 SHALL not take a new interrupt in the RET cycle; the earliest next take is the first IDLE cycle after RET.
REQ-025 SHALL never take an interrupt whose request drops before the take cycle (level semantics, no latching).

Reset
REQ-026 SHALL, while rst_i=0, force state=IDLE, captured index=0, irq_ret_o=0, busy_o=0.
REQ-027 SHALL force trap_o=0 and mcause_o=0 while rst_i=0, regardless of inputs.
REQ-028 SHALL abandon any in-service interrupt when reset is asserted mid-operation, with no irq_ret_o pulse.

Structure
REQ-029 SHALL take the following from shared package irq_pkg: the state enum, NUM_IRQ=16, IRQ_CAUSE_BASE=16, EXC_ILLEGAL_CAUSE=32'h2, INT_CAUSE_FLAG=32'h8000_0000.
REQ-030 SHALL place lowest-index-first selection in sub-module irq_priority_encoder (16-bit in; 4-bit index and valid out).
REQ-031 SHALL register only the state and the captured index; irq_ret_o SHALL decode from the registered state and index.

Verification
REQ-032 Verification SHALL cover: mie_i=32'h0001_0000, irq_req_i=16'h0001 in IDLE -> trap_o=1, mcause_o=32'h8000_0010 same cycle; busy_o=1 next cycle.
REQ-033 Verification SHALL cover: irq_req_i=16'h0006, mie_i=32'h0006_0000 -> mcause_o=32'h8000_0011; after mret_i, irq_ret_o=16'h0002 for exactly one cycle.
REQ-034 Verification SHALL cover: exception_i=1 together with an eligible irq in IDLE -> mcause_o=32'h2, state stays IDLE; with exception_i=0 next cycle -> interrupt trap.
REQ-035 Verification SHALL cover: in HANDLING, irq_req_i=16'hFFFF -> trap_o=0; exception_i=1 -> trap_o=1, mcause_o=2, busy_o stays 1.
REQ-036 Verification SHALL cover: stall_i=1 with an eligible irq -> trap_o=0; after stall_i falls -> trap_o=1 the same cycle.
REQ-037 Verification SHALL cover: rst_i=0 asserted in HANDLING -> busy_o=0 immediately; no irq_ret_o pulse after release.
